frame_sync_scheduler: RTL and testbench
=======================================

# frame_sync_scheduler

Sequences the camera frame-capture datapath. Issues a periodic trigger pulse to up to three cameras and owns the master frame pointer, which rotates over a ring of FRAME_COUNT frame stores. Waits for every participating camera's slave frame pointer to match the master pointer before advancing. Sits between the AXI-lite register block, which supplies enable, mask and period, and the camera write engines, which report slave frame pointers.

## Interface
Parameters:
- FRAME_COUNT, 3: number of frame stores; pointer wraps from FRAME_COUNT-1 to 0 (legal range 2..63).
- TRIG_WIDTH, 16: trigger pulse length in clocks (≥1).

Ports:
- clk  in  1  single clock domain.
- rst  in  1  asynchronous, active-high reset.
- i_enable  in  1  run/stop (level).
- i_cam_mask  in  3  participating cameras; bit n = camera n.
- i_period  in  32  frame period in clocks.
- i_cam0_slave_frame_ptr / i_cam1_… / i_cam2_…  in  6 each  pointer of the frame each camera has completed.
- i_irq_clear  in  1  one-cycle strobe; clears o_interrupt.
- o_master_frame_ptr  out  6  current frame store index.
- o_trigger  out  3  per-camera trigger pulse (= latched mask while pulsing).
- o_frame_stb  out  1  one-cycle strobe on each pointer advance.
- o_overrun_count  out  16  saturating count of missed frames.
- o_interrupt  out  1  sticky overrun flag.
- o_busy  out  1  high in any state other than IDLE.

## Operation
- Reset values: o_master_frame_ptr=0, o_trigger=0, o_frame_stb=0, o_overrun_count=0, o_interrupt=0, o_busy=0, state IDLE. All outputs are registered.
- Latched values: mask M and effective period P = max(i_period, TRIG_WIDTH+1) are latched on every entry to TRIG. Changes take effect at the next frame.
- sync = AND over n in M of (slave_ptr_n == master_ptr). sync=1 when M=0.
- Period counter cnt clears to 0 on TRIG entry and increments every cycle. Period end (PE) is cnt==P-1.
- States:
  - IDLE: outputs quiescent, pointer held. Goes to TRIG when i_enable=1.
  - TRIG: o_trigger=M for TRIG_WIDTH cycles, then WAIT.
  - WAIT: if sync, go to HOLD, or directly ADVANCE if PE in the same cycle. Sync has priority over overrun. If PE and !sync: overrun; o_overrun_count += 1 (saturates at 0xFFFF); o_interrupt=1; pointer not advanced; return to TRIG, which re-triggers the same frame.
  - HOLD: wait for PE, then ADVANCE. Sync is not re-checked.
  - ADVANCE: the transition itself. master_ptr = (ptr==FRAME_COUNT-1) ? 0 : ptr+1, o_frame_stb pulses, enter TRIG.
- i_enable=0 in any state: next cycle the block is in IDLE, o_trigger=0, cnt cleared. Pointer, counters and interrupt are retained.
- i_irq_clear coincident with a new overrun: the set wins and o_interrupt stays 1.
- Reset asserted mid-frame: all state returns to reset values immediately, without waiting for a clock.

## Timing
- i_enable sampled high at edge k: o_busy=1 and o_trigger=M from cycle k+1, held exactly TRIG_WIDTH cycles.
- Steady state with sync: o_frame_stb, the new o_master_frame_ptr and the rising o_trigger all appear in the same cycle, once every P cycles.
- Latency from sync to the pointer advancing is zero if sync arrives on PE, otherwise it is the remainder of the period.
- Overrun: o_overrun_count and o_interrupt update in the cycle after the PE edge. The re-trigger begins in that same cycle, with the pointer unchanged.
- o_frame_stb is never high for two consecutive cycles (P ≥ TRIG_WIDTH+1).

## Test plan
- Reset/idle: assert rst mid-TRIG -> all outputs 0 asynchronously; with i_enable=0 after release, o_busy stays 0.
- Nominal rotation: FRAME_COUNT=3, TRIG_WIDTH=16, P=100, M=3'b111, slaves echo the master pointer 20 cycles after each trigger -> pointer sequence 0,1,2,0 with o_frame_stb every 100 cycles; o_trigger high 16 cycles each frame.
- Overrun: camera1 slave pointer stuck at 0 after the first advance -> at each PE o_overrun_count increments (1,2,…), o_interrupt=1, pointer stays 1, trigger repeats. Apply i_irq_clear -> o_interrupt=0 until the next overrun.
- Mask/edge: M=3'b000 -> advances every P with no trigger bits set. i_period=5 -> effective period 17. Sync exactly at PE -> advance, no overrun.
- Enable drop: deassert i_enable in WAIT with pointer=2 -> IDLE next cycle, o_trigger=0. Re-enable -> triggers the frame with pointer 2, count retained.
- Saturation: preload via 65535 forced overruns (or a shortened bench) -> o_overrun_count holds at 0xFFFF.

Source files
------------

// File: rtl/frame_sync_scheduler.sv
// Frame sync scheduler: periodic camera trigger and master frame pointer.
// Advances the pointer once every participating camera reports the frame.
module frame_sync_scheduler #(
    parameter int FRAME_COUNT = 3,
    parameter int TRIG_WIDTH  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enable,
    input  logic [2:0]  i_cam_mask,
    input  logic [31:0] i_period,
    input  logic [5:0]  i_cam0_slave_frame_ptr,
    input  logic [5:0]  i_cam1_slave_frame_ptr,
    input  logic [5:0]  i_cam2_slave_frame_ptr,
    input  logic        i_irq_clear,
    output logic [5:0]  o_master_frame_ptr,
    output logic [2:0]  o_trigger,
    output logic        o_frame_stb,
    output logic [15:0] o_overrun_count,
    output logic        o_interrupt,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT,
        S_HOLD
    } state_e;

    localparam logic [31:0] MIN_PER   = 32'(TRIG_WIDTH + 1);
    localparam logic [31:0] TRIG_LAST = 32'(TRIG_WIDTH - 1);
    localparam logic [5:0]  PTR_LAST  = 6'(FRAME_COUNT - 1);

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] per_q, per_d;
    logic [2:0]  mask_q, mask_d;
    logic [5:0]  ptr_q, ptr_d;
    logic [15:0] ovr_cnt_q, ovr_cnt_d;
    logic        irq_q, irq_d;
    logic [2:0]  trig_q, trig_d;
    logic        stb_q, stb_d;
    logic        busy_q, busy_d;

    logic [2:0]  hit;
    logic        sync;
    logic        pe;
    logic [31:0] eff_per;

    // Slave pointer match, period end and clamped period for the next frame
    always_comb begin
        hit[0]  = (i_cam0_slave_frame_ptr == ptr_q);
        hit[1]  = (i_cam1_slave_frame_ptr == ptr_q);
        hit[2]  = (i_cam2_slave_frame_ptr == ptr_q);
        sync    = &(hit | ~mask_q);
        pe      = (cnt_q == per_q - 32'd1);
        eff_per = (i_period > MIN_PER) ? i_period : MIN_PER;
    end

    // Next-state and output logic; a frame start re-latches mask and period
    always_comb begin
        logic enter;
        logic ovr;
        enter     = 1'b0;
        ovr       = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q + 32'd1;
        per_d     = per_q;
        mask_d    = mask_q;
        ptr_d     = ptr_q;
        ovr_cnt_d = ovr_cnt_q;
        irq_d     = irq_q;
        trig_d    = trig_q;
        stb_d     = 1'b0;

        if (!i_enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            trig_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: enter = 1'b1;
                S_TRIG: begin
                    if (cnt_q == TRIG_LAST) begin
                        state_d = S_WAIT;
                        trig_d  = '0;
                    end
                end
                S_WAIT: begin
                    if (sync && pe) begin
                        ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 6'd1;
                        stb_d = 1'b1;
                        enter = 1'b1;
                    end else if (sync) begin
                        state_d = S_HOLD;
                    end else if (pe) begin
                        ovr   = 1'b1;
                        enter = 1'b1;
                        if (ovr_cnt_q != 16'hFFFF)
                            ovr_cnt_d = ovr_cnt_q + 16'd1;
                    end
                end
                S_HOLD: begin
                    if (pe) begin
                        ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 6'd1;
                        stb_d = 1'b1;
                        enter = 1'b1;
                    end
                end
            endcase
        end

        if (enter) begin
            state_d = S_TRIG;
            cnt_d   = '0;
            mask_d  = i_cam_mask;
            per_d   = eff_per;
            trig_d  = i_cam_mask;
        end

        if (ovr)
            irq_d = 1'b1;
        else if (i_irq_clear)
            irq_d = 1'b0;

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            per_q     <= MIN_PER;
            mask_q    <= '0;
            ptr_q     <= '0;
            ovr_cnt_q <= '0;
            irq_q     <= 1'b0;
            trig_q    <= '0;
            stb_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            mask_q    <= mask_d;
            ptr_q     <= ptr_d;
            ovr_cnt_q <= ovr_cnt_d;
            irq_q     <= irq_d;
            trig_q    <= trig_d;
            stb_q     <= stb_d;
            busy_q    <= busy_d;
        end
    end

    assign o_master_frame_ptr = ptr_q;
    assign o_trigger          = trig_q;
    assign o_frame_stb        = stb_q;
    assign o_overrun_count    = ovr_cnt_q;
    assign o_interrupt        = irq_q;
    assign o_busy             = busy_q;

endmodule

// File: tb/tb_frame_sync_scheduler.sv
// Bench for frame_sync_scheduler: directed tables, corner sequences,
// and random stimulus against a frame-level reference model.
module tb_frame_sync_scheduler;

    localparam int FC = 3;
    localparam int TW = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [2:0]  mask = '0;
    logic [31:0] period = '0;
    logic [5:0]  sl [3];
    logic        irq_clr = 1'b0;

    logic [5:0]  ptr;
    logic [2:0]  trig;
    logic        stb;
    logic [15:0] ovr;
    logic        irq;
    logic        busy;
    logic [27:0] act_v;

    assign act_v = {ptr, trig, stb, ovr, irq, busy};

    always #5 clk = ~clk;

    frame_sync_scheduler #(
        .FRAME_COUNT(FC),
        .TRIG_WIDTH (TW)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .i_enable              (en),
        .i_cam_mask            (mask),
        .i_period              (period),
        .i_cam0_slave_frame_ptr(sl[0]),
        .i_cam1_slave_frame_ptr(sl[1]),
        .i_cam2_slave_frame_ptr(sl[2]),
        .i_irq_clear           (irq_clr),
        .o_master_frame_ptr    (ptr),
        .o_trigger             (trig),
        .o_frame_stb           (stb),
        .o_overrun_count       (ovr),
        .o_interrupt           (irq),
        .o_busy                (busy)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b1;

    // Reference model: frame-level view (time since trigger, sync seen)
    bit          m_busy;
    longint      m_t;
    longint      m_P;
    bit          m_synced;
    logic [2:0]  m_M;
    int          m_ptr;
    logic [15:0] m_ovr;
    bit          m_irq;
    bit          m_stb;

    task automatic check(input string nm, input logic [63:0] a,
                         input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_t = 0; m_P = TW + 1; m_synced = 0;
        m_M = '0; m_ptr = 0; m_ovr = '0; m_irq = 0; m_stb = 0;
    endtask

    task automatic start_frame();
        m_busy   = 1;
        m_t      = 0;
        m_synced = 0;
        m_M      = mask;
        m_P      = (longint'(period) > TW + 1) ? longint'(period) : TW + 1;
    endtask

    task automatic model_step();
        bit ovr_ev;
        bit sync_now;
        bit seen;
        ovr_ev = 0;
        m_stb  = 0;
        if (!en) begin
            m_busy = 0;
            m_t    = 0;
        end else if (!m_busy) begin
            start_frame();
        end else begin
            sync_now = 1;
            for (int n = 0; n < 3; n++)
                if (m_M[n] && int'(sl[n]) != m_ptr) sync_now = 0;
            seen = m_synced || (m_t >= TW && sync_now);
            if (m_t == m_P - 1) begin
                if (seen) begin
                    m_ptr = (m_ptr + 1) % FC;
                    m_stb = 1;
                end else begin
                    ovr_ev = 1;
                    if (m_ovr != 16'hFFFF) m_ovr = m_ovr + 16'd1;
                end
                start_frame();
            end else begin
                m_synced = seen;
                m_t++;
            end
        end
        if (ovr_ev) m_irq = 1;
        else if (irq_clr) m_irq = 0;
    endtask

    function automatic logic [27:0] exp_v();
        logic [2:0] et;
        et = (m_busy && m_t < TW) ? m_M : 3'b000;
        return {6'(m_ptr), et, m_stb, m_ovr, m_irq, m_busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (chk_en) check("model", act_v, exp_v());
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_sl(input int v);
        for (int n = 0; n < 3; n++) sl[n] = 6'(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("rst_async", act_v, 28'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        en = 1'b0;
        irq_clr = 1'b0;
    endtask

    typedef struct {
        int         c;
        logic [5:0] ptr;
        logic       stb;
        logic [2:0] trig;
        logic       busy;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int f;
        int s;
        tbl[0]  = '{0,   6'd0, 1'b0, 3'd7, 1'b1};
        tbl[1]  = '{15,  6'd0, 1'b0, 3'd7, 1'b1};
        tbl[2]  = '{16,  6'd0, 1'b0, 3'd0, 1'b1};
        tbl[3]  = '{99,  6'd0, 1'b0, 3'd0, 1'b1};
        tbl[4]  = '{100, 6'd1, 1'b1, 3'd7, 1'b1};
        tbl[5]  = '{101, 6'd1, 1'b0, 3'd7, 1'b1};
        tbl[6]  = '{115, 6'd1, 1'b0, 3'd7, 1'b1};
        tbl[7]  = '{116, 6'd1, 1'b0, 3'd0, 1'b1};
        tbl[8]  = '{200, 6'd2, 1'b1, 3'd7, 1'b1};
        tbl[9]  = '{300, 6'd0, 1'b1, 3'd7, 1'b1};
        tbl[10] = '{301, 6'd0, 1'b0, 3'd7, 1'b1};

        set_sl(0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_vals", act_v, 28'd0);

        // Reset asserted mid-trigger, then idle with enable low
        mask = 3'b111; period = 32'd100; en = 1'b1;
        run(5);
        check("mid_trig", {trig, busy}, {3'd7, 1'b1});
        do_reset();
        run(3);
        check("idle_busy", {busy, trig}, 4'd0);

        // Nominal rotation, slaves echo 20 cycles after each trigger
        do_reset();
        mask = 3'b111; period = 32'd100; set_sl(2);
        en = 1'b1;
        for (int c = 0; c <= 301; c++) begin
            tick();
            for (int i = 0; i < 11; i++)
                if (tbl[i].c == c)
                    check($sformatf("nom_c%0d", c), {ptr, stb, trig, busy},
                          {tbl[i].ptr, tbl[i].stb, tbl[i].trig, tbl[i].busy});
            f = c / 100;
            s = (c % 100 >= 20) ? f % 3 : (f + 2) % 3;
            set_sl(s);
        end
        check("nom_ovr", {ovr, irq}, 17'd0);

        // Overrun with camera1 stuck, irq clear, coincident clear/set
        do_reset();
        mask = 3'b111; period = 32'd100; set_sl(0);
        en = 1'b1;
        run(101);
        check("ovr_adv", {ptr, stb}, {6'd1, 1'b1});
        sl[0] = 6'd1; sl[1] = 6'd0; sl[2] = 6'd1;
        run(100);
        check("ovr_1", {ovr, irq, ptr, trig, stb},
              {16'd1, 1'b1, 6'd1, 3'd7, 1'b0});
        run(100);
        check("ovr_2", {ovr, irq, ptr}, {16'd2, 1'b1, 6'd1});
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check("irq_clr", {ovr, irq}, {16'd2, 1'b0});
        run(98);
        check("irq_low", irq, 1'b0);
        tick();
        check("ovr_3", {ovr, irq}, {16'd3, 1'b1});
        run(99);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check("set_wins", {ovr, irq}, {16'd4, 1'b1});
        sl[1] = 6'd1;
        run(100);
        check("adv_p2", {ptr, stb, ovr}, {6'd2, 1'b1, 16'd4});

        // Enable drop while waiting on pointer 2, then re-enable
        run(20);
        en = 1'b0;
        tick();
        check("en_drop", {busy, trig, ptr, ovr}, {1'b0, 3'd0, 6'd2, 16'd4});
        run(2);
        en = 1'b1;
        tick();
        check("re_en", {busy, trig, ptr, ovr, stb},
              {1'b1, 3'd7, 6'd2, 16'd4, 1'b0});

        // Empty mask with short period clamps to TRIG_WIDTH+1
        do_reset();
        mask = 3'b000; period = 32'd5;
        en = 1'b1;
        tick();
        check("m0_trig", {trig, busy}, {3'd0, 1'b1});
        run(16);
        check("m0_c16", {ptr, stb}, {6'd0, 1'b0});
        tick();
        check("m0_c17", {ptr, stb}, {6'd1, 1'b1});
        run(17);
        check("m0_c34", {ptr, stb, ovr}, {6'd2, 1'b1, 16'd0});

        // Sync arriving exactly on the period-end cycle
        do_reset();
        mask = 3'b001; period = 32'd5; set_sl(1);
        en = 1'b1;
        run(17);
        sl[0] = 6'd0;
        tick();
        check("sync_pe", {ptr, stb, ovr, irq}, {6'd1, 1'b1, 16'd0, 1'b0});

        // Saturation of the overrun counter
        do_reset();
        chk_en = 1'b0;
        force dut.ovr_cnt_q = 16'hFFFE;
        tick();
        release dut.ovr_cnt_q;
        m_ovr = 16'hFFFE;
        chk_en = 1'b1;
        tick();
        check("sat_pre", ovr, 16'hFFFE);
        mask = 3'b001; period = 32'd5; set_sl(1);
        en = 1'b1;
        run(18);
        check("sat_1", ovr, 16'hFFFF);
        run(34);
        check("sat_hold", {ovr, irq}, {16'hFFFF, 1'b1});

        // Random stimulus against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            en      = ($urandom_range(0, 99) != 0);
            irq_clr = ($urandom_range(0, 15) == 0);
            mask    = 3'($urandom_range(0, 7));
            period  = $urandom_range(0, 40);
            for (int n = 0; n < 3; n++)
                sl[n] = $urandom_range(0, 1) ? 6'(m_ptr)
                                             : 6'($urandom_range(0, FC - 1));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
